// File: rtl/uart_line_arbiter.sv
// Two-requester arbiter feeding whole ASCII lines to a byte-serial line feeder.
// Each requester owns a one-deep line buffer; grants alternate when both are pending.
module uart_line_arbiter #(
  parameter int PARM_LINE_BYTES = 34,
  parameter int PARM_GAP_CYCLES = 2
) (
  input  logic                         i_clk_20mhz,
  input  logic                         i_rst_20mhz,
  input  logic                         i_req0_go,
  input  logic [8*PARM_LINE_BYTES-1:0] i_req0_line,
  input  logic                         i_req1_go,
  input  logic [8*PARM_LINE_BYTES-1:0] i_req1_line,
  input  logic                         i_feed_valid,
  output logic                         o_tx_go,
  output logic [8*PARM_LINE_BYTES-1:0] o_dat_ascii_line,
  output logic [1:0]                   o_req_done,
  output logic [1:0]                   o_req_overrun,
  output logic                         o_busy
);

  localparam int LINE_W = 8 * PARM_LINE_BYTES;
  localparam int GAP_W  = (PARM_GAP_CYCLES > 1) ? $clog2(PARM_GAP_CYCLES) : 1;

  localparam logic [5:0]       CNT_LAST  = 6'(PARM_LINE_BYTES - 1);
  localparam logic [5:0]       CNT_FULL  = 6'(PARM_LINE_BYTES);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(PARM_GAP_CYCLES - 1);
  // Idle line content: spaces terminated by CR LF, so a stray feed prints a blank line.
  localparam logic [LINE_W-1:0] BLANK_LINE = {{(PARM_LINE_BYTES-2){8'h20}}, 8'h0D, 8'h0A};

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_GAP
  } state_t;

  state_t            state;
  logic [LINE_W-1:0] line_buf [2];
  logic [1:0]        pending;
  logic [1:0]        req_go;
  logic [1:0]        grant_clr;
  logic              winner;
  logic              last_grant;
  logic [5:0]        byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  assign req_go    = {i_req1_go, i_req0_go};
  // A request landing in the same cycle as its grant re-arms pending for a later turn.
  assign grant_clr = (state == S_GRANT) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: all state here is registered with non-blocking assignments so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state            <= S_IDLE;
      // NOTE: the line buffers are deliberately reset; a line served before any
      // request was captured must still be a well-formed blank line.
      line_buf[0]      <= BLANK_LINE;
      line_buf[1]      <= BLANK_LINE;
      o_dat_ascii_line <= BLANK_LINE;
      pending          <= 2'b00;
      winner           <= 1'b0;
      last_grant       <= 1'b1;
      byte_cnt         <= '0;
      gap_cnt          <= '0;
      o_tx_go          <= 1'b0;
      o_req_done       <= 2'b00;
      o_req_overrun    <= 2'b00;
      o_busy           <= 1'b0;
    end else begin
      o_req_done    <= 2'b00;
      o_req_overrun <= req_go & pending & ~grant_clr;
      pending       <= req_go | (pending & ~grant_clr);
      if (i_req0_go) line_buf[0] <= i_req0_line;
      if (i_req1_go) line_buf[1] <= i_req1_line;

      case (state)
        S_IDLE: begin
          if (|pending) begin
            state  <= S_GRANT;
            o_busy <= 1'b1;
            winner <= (pending == 2'b11) ? ~last_grant : pending[1];
          end
        end

        S_GRANT: begin
          o_dat_ascii_line <= line_buf[winner];
          byte_cnt         <= '0;
          last_grant       <= winner;
          o_tx_go          <= 1'b1;
          state            <= S_SEND;
        end

        S_SEND: begin
          if (i_feed_valid) begin
            if (byte_cnt == CNT_LAST) begin
              byte_cnt   <= CNT_FULL;
              gap_cnt    <= '0;
              o_tx_go    <= 1'b0;
              o_req_done <= winner ? 2'b10 : 2'b01;
              state      <= S_GAP;
            end else begin
              byte_cnt <= byte_cnt + 6'd1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          o_tx_go <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Scoreboard bench for uart_line_arbiter: lines are queued when requested and
// compared when the arbiter raises o_tx_go.
module tb_uart_line_arbiter;

  localparam int LB = 34;
  localparam int LW = 8 * LB;
  localparam logic [LW-1:0] BLANK = {{32{8'h20}}, 8'h0D, 8'h0A};

  typedef struct {
    logic [LW-1:0] line;
    logic [1:0]    done;
  } sb_item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_go = 1'b0;
  logic          req1_go = 1'b0;
  logic          feed_valid = 1'b0;
  logic [LW-1:0] req0_line = '0;
  logic [LW-1:0] req1_line = '0;
  logic          tx_go;
  logic [LW-1:0] dat_line;
  logic [1:0]    req_done;
  logic [1:0]    req_overrun;
  logic          busy;

  sb_item_t sb[$];
  int errors = 0;
  int checks = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int ovr_cnt0 = 0;
  int ovr_cnt1 = 0;

  uart_line_arbiter #(
    .PARM_LINE_BYTES(LB),
    .PARM_GAP_CYCLES(2)
  ) dut (
    .i_clk_20mhz     (clk),
    .i_rst_20mhz     (rst),
    .i_req0_go       (req0_go),
    .i_req0_line     (req0_line),
    .i_req1_go       (req1_go),
    .i_req1_line     (req1_line),
    .i_feed_valid    (feed_valid),
    .o_tx_go         (tx_go),
    .o_dat_ascii_line(dat_line),
    .o_req_done      (req_done),
    .o_req_overrun   (req_overrun),
    .o_busy          (busy)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (req_done[0] === 1'b1) done_cnt0++;
    if (req_done[1] === 1'b1) done_cnt1++;
    if (req_overrun[0] === 1'b1) ovr_cnt0++;
    if (req_overrun[1] === 1'b1) ovr_cnt1++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] make_line(input logic [7:0] c);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < LB - 2; i++) l[LW-1-8*i -: 8] = c + 8'(i);
    l[15:0] = 16'h0D0A;
    return l;
  endfunction

  // Latest-wins model: a request from a requester still queued replaces its line.
  task automatic sb_expect(input int r, input logic [LW-1:0] line);
    bit found;
    found = 1'b0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].done[r] === 1'b1) begin
        sb[i].line = line;
        found = 1'b1;
      end
    end
    if (!found) sb.push_back(sb_item_t'{line, (r == 1) ? 2'b10 : 2'b01});
  endtask

  task automatic request(input int r, input logic [LW-1:0] line);
    sb_expect(r, line);
    if (r == 0) begin
      req0_line = line;
      req0_go   = 1'b1;
    end else begin
      req1_line = line;
      req1_go   = 1'b1;
    end
    tick;
    req0_go = 1'b0;
    req1_go = 1'b0;
  endtask

  task automatic request_both(input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    sb_expect(0, l0);
    sb_expect(1, l1);
    req0_line = l0;
    req1_line = l1;
    req0_go   = 1'b1;
    req1_go   = 1'b1;
    tick;
    req0_go = 1'b0;
    req1_go = 1'b0;
  endtask

  task automatic wait_tx_go(input string tag, output bit ok);
    int waited;
    waited = 0;
    while (tx_go !== 1'b1 && waited < 200) begin
      tick;
      waited++;
    end
    checks++;
    ok = (tx_go === 1'b1);
    if (!ok) begin
      errors++;
      $display("FAIL %s tx_go_rise: got %b after %0d cycles, want 1", tag, tx_go, waited);
    end
  endtask

  // Serves one granted line: checks content, exactly LB pulses, done pulse and gap.
  task automatic serve_one(input string tag, input bit stray_gap);
    sb_item_t exp;
    bit ok;
    wait_tx_go(tag, ok);
    if (!ok) return;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: got a grant (line %h), want none", tag, dat_line);
      return;
    end
    exp = sb.pop_front();
    checks++;
    if (dat_line !== exp.line) begin
      errors++;
      $display("FAIL %s line: got %h want %h", tag, dat_line, exp.line);
    end
    for (int i = 0; i < LB - 1; i++) begin
      feed_valid = 1'b1;
      tick;
      feed_valid = 1'b0;
      if (i % 4 == 1) tick;
    end
    checks++;
    if (tx_go !== 1'b1 || req_done !== 2'b00) begin
      errors++;
      $display("FAIL %s early_end: got tx_go=%b done=%b want tx_go=1 done=00", tag, tx_go, req_done);
    end
    feed_valid = 1'b1;
    tick;
    feed_valid = 1'b0;
    checks++;
    if (tx_go !== 1'b0) begin
      errors++;
      $display("FAIL %s tx_go_fall: got %b want 0", tag, tx_go);
    end
    checks++;
    if (req_done !== exp.done) begin
      errors++;
      $display("FAIL %s done: got %b want %b", tag, req_done, exp.done);
    end
    if (stray_gap) feed_valid = 1'b1;
    tick;
    checks++;
    if (req_done !== 2'b00 || tx_go !== 1'b0 || dat_line !== exp.line) begin
      errors++;
      $display("FAIL %s gap1: got done=%b tx_go=%b line=%h want done=00 tx_go=0 line=%h",
               tag, req_done, tx_go, dat_line, exp.line);
    end
    tick;
    feed_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_go !== 1'b0) begin
      errors++;
      $display("FAIL %s gap_end: got busy=%b tx_go=%b want busy=0 tx_go=0", tag, busy, tx_go);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if (tx_go !== 1'b0 || busy !== 1'b0 || req_done !== 2'b00 || req_overrun !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: got tx_go=%b busy=%b done=%b ovr=%b want 0 0 00 00",
               tx_go, busy, req_done, req_overrun);
    end
    checks++;
    if (dat_line !== BLANK) begin
      errors++;
      $display("FAIL reset_line: got %h want %h", dat_line, BLANK);
    end
  endtask

  task automatic test_single;
    int d0;
    d0 = done_cnt0;
    request(0, make_line("A"));
    checks++;
    if (busy !== 1'b0 || tx_go !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: got busy=%b tx_go=%b want 0 0", busy, tx_go);
    end
    tick;
    checks++;
    if (busy !== 1'b1 || tx_go !== 1'b0) begin
      errors++;
      $display("FAIL single_grant_c2: got busy=%b tx_go=%b want 1 0", busy, tx_go);
    end
    tick;
    checks++;
    if (tx_go !== 1'b1) begin
      errors++;
      $display("FAIL single_send_c3: got tx_go=%b want 1", tx_go);
    end
    serve_one("single", 1'b1);
    checks++;
    if (done_cnt0 - d0 != 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d want 1", done_cnt0 - d0);
    end
  endtask

  task automatic test_stray_idle;
    feed_valid = 1'b1;
    repeat (3) tick;
    feed_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_go !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: got busy=%b tx_go=%b want 0 0", busy, tx_go);
    end
    request(1, make_line("s"));
    serve_one("after_stray", 1'b0);
  endtask

  task automatic test_simultaneous;
    int d0, d1;
    d0 = done_cnt0;
    d1 = done_cnt1;
    request_both(make_line("B"), make_line("b"));
    serve_one("simul_first", 1'b0);
    serve_one("simul_second", 1'b0);
    checks++;
    if (done_cnt0 - d0 != 1 || done_cnt1 - d1 != 1) begin
      errors++;
      $display("FAIL simul_done_count: got %0d,%0d want 1,1", done_cnt0 - d0, done_cnt1 - d1);
    end
  endtask

  task automatic test_fairness;
    request_both(make_line("C"), make_line("c"));
    fork
      serve_one("fair_0a", 1'b0);
      begin repeat (10) tick; request(0, make_line("D")); end
    join
    fork
      serve_one("fair_1a", 1'b0);
      begin repeat (10) tick; request(1, make_line("d")); end
    join
    serve_one("fair_0b", 1'b0);
    serve_one("fair_1b", 1'b0);
  endtask

  task automatic test_overrun;
    int o1, o0, d1;
    o0 = ovr_cnt0;
    o1 = ovr_cnt1;
    d1 = done_cnt1;
    request(0, make_line("E"));
    fork
      serve_one("ovr_req0", 1'b0);
      begin
        repeat (6) tick;
        request(1, make_line("x"));
        checks++;
        if (req_overrun !== 2'b00) begin
          errors++;
          $display("FAIL ovr_first: got %b want 00", req_overrun);
        end
        repeat (4) tick;
        request(1, make_line("y"));
        checks++;
        if (req_overrun !== 2'b10) begin
          errors++;
          $display("FAIL ovr_second: got %b want 10", req_overrun);
        end
      end
    join
    serve_one("ovr_req1", 1'b0);
    checks++;
    if (ovr_cnt1 - o1 != 1 || ovr_cnt0 != o0 || done_cnt1 - d1 != 1) begin
      errors++;
      $display("FAIL ovr_counts: got ovr1=%0d ovr0=%0d done1=%0d want 1 0 1",
               ovr_cnt1 - o1, ovr_cnt0 - o0, done_cnt1 - d1);
    end
  endtask

  task automatic test_reset_mid_send;
    int d0, d1;
    bit ok;
    request(0, make_line("F"));
    wait_tx_go("rst_mid", ok);
    for (int i = 0; i < 20; i++) begin
      feed_valid = 1'b1;
      tick;
      feed_valid = 1'b0;
      if (i == 5) request(1, make_line("f"));
    end
    d0 = done_cnt0;
    d1 = done_cnt1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    checks++;
    if (tx_go !== 1'b0 || busy !== 1'b0 || req_done !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got tx_go=%b busy=%b done=%b want 0 0 00", tx_go, busy, req_done);
    end
    checks++;
    if (dat_line !== BLANK) begin
      errors++;
      $display("FAIL rst_mid_line: got %h want %h", dat_line, BLANK);
    end
    repeat (6) tick;
    checks++;
    if (busy !== 1'b0 || done_cnt0 != d0 || done_cnt1 != d1) begin
      errors++;
      $display("FAIL rst_mid_discard: got busy=%b done pulses=%0d,%0d want 0 0,0",
               busy, done_cnt0 - d0, done_cnt1 - d1);
    end
  endtask

  task automatic test_reset_vs_request;
    rst     = 1'b1;
    req0_go = 1'b1;
    req0_line = make_line("G");
    tick;
    rst     = 1'b0;
    req0_go = 1'b0;
    repeat (4) tick;
    checks++;
    if (busy !== 1'b0 || tx_go !== 1'b0) begin
      errors++;
      $display("FAIL rst_dominates: got busy=%b tx_go=%b want 0 0", busy, tx_go);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stray_idle();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_reset_mid_send();
    test_reset_vs_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_line_arbiter.md
UART_LINE_ARBITER -- requirements
Module: uart_line_arbiter

Interface
REQ-001 Parameter: PARM_LINE_BYTES, 34, bytes per ASCII line (line width = 8*PARM_LINE_BYTES = 272 bits).
REQ-002 Parameter: PARM_GAP_CYCLES, 2, minimum cycles o_tx_go stays low between two served lines.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk_20mhz  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst_20mhz  in  1  synchronous active-high reset.
REQ-006 i_req0_go  in  1  requester 0 single-cycle line-send request.
REQ-007 i_req0_line  in  272  requester 0 line; MSB byte is sent first.
REQ-008 i_req1_go  in  1  requester 1 single-cycle line-send request.
REQ-009 i_req1_line  in  272  requester 1 line.
REQ-010 i_feed_valid  in  1  byte-valid strobe from the line feeder, one pulse per byte enqueued.
REQ-011 o_tx_go  out  1  level request to the line feeder.
REQ-012 o_dat_ascii_line  out  272  line presented to the feeder.
REQ-013 o_req_done  out  2  per-requester single-cycle completion pulse; bit n = requester n.
REQ-014 o_req_overrun  out  2  per-requester single-cycle pulse when a request overwrites a still-pending one.
REQ-015 o_busy  out  1  high in every state except IDLE.

Function
REQ-016 i_reqN_go high at edge N captures i_reqN_line into buffer N and sets pending[N], both visible from cycle N+1.
REQ-017 i_reqN_go while pending[N] already set: buffer N overwritten (latest wins), pending stays set, o_req_overrun[N] pulses in cycle N+1.
REQ-018 A request from requester n while n is being served sets pending[n] for a later grant; it does not disturb the line in service.
REQ-019 FSM states: IDLE, GRANT, SEND, GAP.
REQ-020 IDLE: no pending -> stay; any pending -> GRANT.
REQ-021 Arbitration at IDLE->GRANT: single pending wins; both pending -> the requester not granted last wins; the last-granted pointer resets to requester 1, so requester 0 wins first.
REQ-022 GRANT: copy the winner's buffer to o_dat_ascii_line, clear the winner's pending bit (unless a new request arrives the same cycle), zero the byte counter, record the winner, -> SEND; o_tx_go low.
REQ-023 SEND: o_tx_go high; the byte counter increments on each i_feed_valid; when a pulse brings it to PARM_LINE_BYTES -> GAP.
REQ-024 o_dat_ascii_line is held constant from GRANT through the end of GAP.
REQ-025 GAP entry: o_tx_go low from the first GAP cycle; o_req_done[winner] pulses for exactly one cycle on GAP entry.
REQ-026 GAP duration: stay PARM_GAP_CYCLES cycles, then -> IDLE.
REQ-027 Throughput: a new grant cannot reach SEND sooner than PARM_GAP_CYCLES+2 cycles after o_tx_go falls.
REQ-028 i_feed_valid outside SEND is ignored.
REQ-029 The byte counter is 6 bits and never exceeds PARM_LINE_BYTES.
REQ-030 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-031 Reset values: state IDLE, o_tx_go 0, o_req_done 0, o_req_overrun 0, o_busy 0, pending 00, counter 0, pointer = requester 1.
REQ-032 Reset values: both buffers and o_dat_ascii_line = 32 x 0x20 followed by 0x0D 0x0A.
REQ-033 Reset mid-SEND: o_tx_go low from the next cycle; no o_req_done pulse; a pending request is discarded.
REQ-034 Reset dominates a request in the same cycle; that request is lost.

Verification
REQ-035 Single request: req0 with line "A..." at cycle 0 -> GRANT at cycle 2, o_tx_go high at cycle 3; after 34 i_feed_valid pulses, o_tx_go falls, o_req_done=01 for one cycle, o_busy low 2 cycles later.
REQ-036 Simultaneous: req0 and req1 in the same cycle after reset -> line0 served first, then line1; o_tx_go low at least 2 cycles between them; done=01, then done=10.
REQ-037 Fairness: req0 and req1 both re-request continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row while the other is pending.
REQ-038 Overrun: req1 twice, 5 cycles apart, while req0 is in SEND -> o_req_overrun=10 once; the second req1 line is the one transmitted; one done pulse for req1.
REQ-039 Reset at byte 20 of SEND -> o_tx_go 0 next cycle; no done pulse; o_busy 0; o_dat_ascii_line = 32 spaces + CR LF.
REQ-040 Stray i_feed_valid pulses in IDLE and GAP -> no counter change; the next line still requires exactly 34 pulses.
